// File: rtl/elevator.sv
// Single-car elevator controller for floors 0-7 with a 7-segment floor display
// and an RGB status LED. There is no request queue and emergencies take priority.
module elevator #(
   parameter int unsigned COUNT_20S = 2000000000,
   parameter int unsigned COUNT_1S  = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic       direction,
   input  logic [2:0] req_floor,
   input  logic       emergency,
   output logic [6:0] cathode,
   output logic [7:0] anode,
   output logic       r,
   output logic       g,
   output logic       b
);

   typedef enum logic [2:0] {
      RESET       = 3'd0,
      IDLE        = 3'd1,
      MOVING_UP   = 3'd2,
      MOVING_DOWN = 3'd3,
      DOOR_OPEN   = 3'd4,
      DOOR_CLOSE  = 3'd5,
      EMERGENCY   = 3'd6
   } state_t;

   localparam logic [31:0] LAST_1S  = 32'(COUNT_1S - 1);
   localparam logic [31:0] LAST_20S = 32'(COUNT_20S - 1);

   state_t      current_state;
   logic [2:0]  current_floor;
   logic [2:0]  target;
   logic [31:0] counter;
   logic [2:0]  floor_up;
   logic [2:0]  floor_down;
   logic        direction_unused;

   // Travel direction comes only from comparing target with current_floor.
   assign direction_unused = direction;

   assign floor_up   = current_floor + 3'd1;
   assign floor_down = current_floor - 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         current_state <= RESET;
         current_floor <= '0;
         target        <= '0;
         counter       <= '0;
      end else if (valid_in && emergency) begin
         current_state <= EMERGENCY;
         counter       <= '0;
      end else begin
         case (current_state)
            RESET: begin
               current_state <= IDLE;
            end

            IDLE: begin
               if (valid_in) begin
                  target  <= req_floor;
                  counter <= '0;
                  if (req_floor > current_floor)
                     current_state <= MOVING_UP;
                  else if (req_floor < current_floor)
                     current_state <= MOVING_DOWN;
                  else
                     current_state <= DOOR_OPEN;
               end
            end

            MOVING_UP: begin
               if (counter == LAST_1S) begin
                  counter <= '0;
                  // The top-floor guard keeps the floor from wrapping even if target is stale.
                  if (current_floor != 3'd7) begin
                     current_floor <= floor_up;
                     if (floor_up == target)
                        current_state <= DOOR_OPEN;
                  end else begin
                     current_state <= DOOR_OPEN;
                  end
               end else begin
                  counter <= counter + 32'd1;
               end
            end

            MOVING_DOWN: begin
               if (counter == LAST_1S) begin
                  counter <= '0;
                  if (current_floor != 3'd0) begin
                     current_floor <= floor_down;
                     if (floor_down == target)
                        current_state <= DOOR_OPEN;
                  end else begin
                     current_state <= DOOR_OPEN;
                  end
               end else begin
                  counter <= counter + 32'd1;
               end
            end

            DOOR_OPEN: begin
               if (counter == LAST_20S) begin
                  counter       <= '0;
                  current_state <= DOOR_CLOSE;
               end else begin
                  counter <= counter + 32'd1;
               end
            end

            DOOR_CLOSE: begin
               if (counter == LAST_1S) begin
                  counter       <= '0;
                  current_state <= IDLE;
               end else begin
                  counter <= counter + 32'd1;
               end
            end

            EMERGENCY: begin
               // The clearing request's floor is discarded.
               if (valid_in) begin
                  counter       <= '0;
                  current_state <= IDLE;
               end
            end

            default: begin
               current_state <= RESET;
               counter       <= '0;
            end
         endcase
      end
   end

   always_comb begin
      anode = ~(8'b0000_0001 << current_floor);
   end

   always_comb begin
      cathode = 7'b1111111;
      case (current_floor)
         3'd0: cathode = 7'b0000001;
         3'd1: cathode = 7'b1001111;
         3'd2: cathode = 7'b0010010;
         3'd3: cathode = 7'b0000110;
         3'd4: cathode = 7'b1001100;
         3'd5: cathode = 7'b0100100;
         3'd6: cathode = 7'b0100000;
         3'd7: cathode = 7'b0001111;
         default: cathode = 7'b1111111;
      endcase
   end

   always_comb begin
      {r, g, b} = 3'b000;
      case (current_state)
         RESET:       {r, g, b} = 3'b000;
         IDLE:        {r, g, b} = 3'b010;
         MOVING_UP:   {r, g, b} = 3'b001;
         MOVING_DOWN: {r, g, b} = 3'b110;
         DOOR_OPEN:   {r, g, b} = 3'b011;
         DOOR_CLOSE:  {r, g, b} = 3'b101;
         EMERGENCY:   {r, g, b} = 3'b100;
         default:     {r, g, b} = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_elevator.sv
// Directed bench for elevator with short timing constants (20-cycle dwell, 10-cycle floor).
// Every expected LED/display value below comes from hand-derived constants.
module tb_elevator;

   localparam int unsigned C20 = 20;
   localparam int unsigned C1  = 10;

   localparam logic [2:0] RGB_RESET = 3'b000;
   localparam logic [2:0] RGB_IDLE  = 3'b010;
   localparam logic [2:0] RGB_UP    = 3'b001;
   localparam logic [2:0] RGB_DOWN  = 3'b110;
   localparam logic [2:0] RGB_OPEN  = 3'b011;
   localparam logic [2:0] RGB_CLOSE = 3'b101;
   localparam logic [2:0] RGB_EMERG = 3'b100;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid_in = 1'b0;
   logic       direction = 1'b0;
   logic [2:0] req_floor = 3'd0;
   logic       emergency = 1'b0;
   logic [6:0] cathode;
   logic [7:0] anode;
   logic       r, g, b;

   int n_checks = 0;
   int n_fail   = 0;

   elevator #(.COUNT_20S(C20), .COUNT_1S(C1)) dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .direction (direction),
      .req_floor (req_floor),
      .emergency (emergency),
      .cathode   (cathode),
      .anode     (anode),
      .r         (r),
      .g         (g),
      .b         (b)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int floor);
      case (floor)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [7:0] digit(input int floor);
      logic [7:0] a;
      a = 8'hFF;
      a[floor] = 1'b0;
      return a;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] rgb, input int floor);
      chk({tag, "_rgb"}, {5'b0, r, g, b}, {5'b0, rgb});
      chk({tag, "_anode"}, anode, digit(floor));
      chk({tag, "_cathode"}, {1'b0, cathode}, {1'b0, seg(floor)});
   endtask

   // Checks then advances n cycles; floor = start + step * ((k0 + k) / C1).
   task automatic phase(input string tag, input logic [2:0] rgb, input int start,
                        input int step, input int k0, input int n);
      for (int k = 0; k < n; k++) begin
         check_all(tag, rgb, start + step * ((k0 + k) / int'(C1)));
         tick();
      end
   endtask

   task automatic request(input logic dir, input logic [2:0] floor, input logic emerg);
      valid_in  = 1'b1;
      direction = dir;
      req_floor = floor;
      emergency = emerg;
      tick();
      valid_in  = 1'b0;
      emergency = 1'b0;
   endtask

   task automatic doors(input string tag, input int floor);
      phase({tag, "_open"}, RGB_OPEN, floor, 0, 0, int'(C20));
      phase({tag, "_close"}, RGB_CLOSE, floor, 0, 0, int'(C1));
      check_all({tag, "_idle"}, RGB_IDLE, floor);
   endtask

   initial begin
      // Reset held through an edge, then released.
      #2;
      check_all("reset", RGB_RESET, 0);
      tick();
      check_all("reset_held", RGB_RESET, 0);
      reset = 1'b1;
      tick();
      check_all("first_idle", RGB_IDLE, 0);

      // Floor 0 -> 3 up; a request made mid-travel is ignored.
      request(1'b1, 3'd3, 1'b0);
      phase("up3", RGB_UP, 0, 1, 0, 15);
      valid_in  = 1'b1;
      req_floor = 3'd6;
      direction = 1'b0;
      phase("up3_ignored", RGB_UP, 0, 1, 15, 1);
      valid_in  = 1'b0;
      phase("up3_tail", RGB_UP, 0, 1, 16, 14);
      chk("up3_anode_end", anode, 8'b11110111);
      chk("up3_cathode_end", {1'b0, cathode}, 8'b00000110);
      doors("at3", 3);

      // Floor 3 -> 1 down.
      request(1'b0, 3'd1, 1'b0);
      phase("down1", RGB_DOWN, 3, -1, 0, 20);
      chk("down1_cathode_end", {1'b0, cathode}, 8'b01001111);
      doors("at1", 1);

      // Emergency while idle, other traffic ignored, then cleared without moving.
      request(1'b1, 3'd4, 1'b1);
      check_all("emerg_idle", RGB_EMERG, 1);
      req_floor = 3'd7;
      tick();
      tick();
      check_all("emerg_hold", RGB_EMERG, 1);
      request(1'b1, 3'd4, 1'b0);
      check_all("emerg_clear", RGB_IDLE, 1);
      tick();
      tick();
      check_all("emerg_nomove", RGB_IDLE, 1);

      // Emergency mid-travel freezes floor 2.
      request(1'b1, 3'd4, 1'b0);
      phase("up4", RGB_UP, 1, 1, 0, 15);
      request(1'b1, 3'd4, 1'b1);
      check_all("emerg_travel", RGB_EMERG, 2);
      phase("emerg_frozen", RGB_EMERG, 2, 0, 0, 12);
      request(1'b0, 3'd6, 1'b0);
      check_all("emerg_travel_clear", RGB_IDLE, 2);
      tick();
      check_all("emerg_travel_nomove", RGB_IDLE, 2);

      // Floor 2 -> 5, then back to 2.
      request(1'b1, 3'd5, 1'b0);
      phase("up5", RGB_UP, 2, 1, 0, 30);
      doors("at5", 5);
      request(1'b0, 3'd2, 1'b0);
      phase("down2", RGB_DOWN, 5, -1, 0, 30);
      doors("at2", 2);

      // Same-floor request opens the door directly.
      request(1'b1, 3'd2, 1'b0);
      doors("same2", 2);

      // Emergency wins over a pending door sequence.
      request(1'b0, 3'd2, 1'b0);
      phase("same2b_open", RGB_OPEN, 2, 0, 0, 5);
      request(1'b0, 3'd0, 1'b1);
      check_all("emerg_door", RGB_EMERG, 2);
      request(1'b0, 3'd0, 1'b0);
      check_all("emerg_door_clear", RGB_IDLE, 2);

      // Asynchronous reset mid-travel.
      request(1'b1, 3'd7, 1'b0);
      phase("up7", RGB_UP, 2, 1, 0, 12);
      #3;
      reset = 1'b0;
      #1;
      check_all("async_reset", RGB_RESET, 0);
      tick();
      check_all("async_reset_held", RGB_RESET, 0);
      reset = 1'b1;
      tick();
      check_all("post_reset_idle", RGB_IDLE, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
